out_port_bank: RTL and testbench

Parametrised output-port bank for the Nibbler CPU. It provides NUM_PORTS independent output registers, each DATA_W bits wide, written from the CPU data bus. Each write selects a port and a read-modify-write mode (load, set, clear or toggle bits). Each port has an optional valid/ack handshake toward its external peripheral, and the CPU is stalled on a write to a port whose previous value has not been taken.

---
 rtl/nibbler_out_pkg.sv | 13 +
 rtl/out_chan.sv | 57 +++++
 rtl/out_port_bank.sv | 72 +++++++
 tb/tb_out_port_bank.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nibbler_out_pkg.sv
// Shared types for the Nibbler output-port bank: write modes and default nibble width.
package nibbler_out_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_SET  = 2'b01,
    MODE_CLR  = 2'b10,
    MODE_TGL  = 2'b11
  } out_mode_t;

endpackage

// File: rtl/out_chan.sv
// One output channel: port register with read-modify-write ALU and pending/strobe bit.
// Data and valid update one edge after wr; acks are only honoured in handshake mode.
module out_chan
  import nibbler_out_pkg::*;
#(
  parameter int              DATA_W    = NIB_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit              HANDSHAKE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] d,
  input  logic              ack,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  logic [DATA_W-1:0] q_q, q_d, alu;
  logic              valid_q, valid_d;

  always_comb begin
    alu = q_q;
    case (out_mode_t'(mode))
      MODE_LOAD: alu = d;
      MODE_SET:  alu = q_q | d;
      MODE_CLR:  alu = q_q & ~d;
      MODE_TGL:  alu = q_q ^ d;
      default:   alu = q_q;
    endcase
  end

  always_comb begin
    q_d = wr ? alu : q_q;
    // A write in the same cycle as an ack wins: the ack retired the old value.
    if (HANDSHAKE) begin
      valid_d = wr ? 1'b1 : (ack ? 1'b0 : valid_q);
    end else begin
      valid_d = wr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q     <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;

endmodule

// File: rtl/out_port_bank.sv
// Bank of NUM_PORTS output registers written from the CPU bus; stalls the CPU while the
// target port still holds an unacknowledged value, and flags writes to nonexistent ports.
module out_port_bank
  import nibbler_out_pkg::*;
#(
  parameter int                DATA_W    = NIB_W,
  parameter int                NUM_PORTS = 4,
  parameter int                SEL_W     = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                HANDSHAKE = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [SEL_W-1:0]            port_sel,
  input  logic [1:0]                  mode,
  input  logic [DATA_W-1:0]           data_bus,
  output logic                        stall,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ack,
  output logic                        sel_err
);

  localparam int             SEL_N = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_P = (SEL_W + 1)'(NUM_PORTS);

  logic [SEL_N-1:0] pend_pad, ack_pad;
  logic             in_range, accept;
  logic             sel_err_q, sel_err_d;

  // Pad to the full select range so port_sel can index without going out of bounds.
  assign pend_pad = SEL_N'(out_valid);
  assign ack_pad  = SEL_N'(out_ack);

  assign in_range = ({1'b0, port_sel} < NUM_P);
  assign stall    = en & in_range & HANDSHAKE & pend_pad[port_sel] & ~ack_pad[port_sel];
  assign accept   = en & in_range & ~stall;

  assign sel_err_d = sel_err_q | (en & ~in_range);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_chan
    logic wr;
    assign wr = accept & (port_sel == SEL_W'(k));

    out_chan #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL),
      .HANDSHAKE (HANDSHAKE)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .wr    (wr),
      .mode  (mode),
      .d     (data_bus),
      .ack   (out_ack[k]),
      .q     (data_out[k*DATA_W +: DATA_W]),
      .valid (out_valid[k])
    );
  end

endmodule

// File: tb/tb_out_port_bank.sv
// Bench: a 4-port handshake bank and a 3-port strobe bank (reset value 9) checked against a
// behavioural model through an expectation queue drained by a negedge monitor.
module tb_out_port_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        en0, en1;
  logic [1:0]  sel0, sel1, mode0, mode1;
  logic [3:0]  d0, d1, ack0;
  logic [2:0]  ack1;
  logic        stall0, stall1, serr0, serr1;
  logic [15:0] dout0;
  logic [11:0] dout1;
  logic [3:0]  v0;
  logic [2:0]  v1;

  always #5 clk = ~clk;

  out_port_bank #(.DATA_W(4), .NUM_PORTS(4), .SEL_W(2), .RESET_VAL(4'h0), .HANDSHAKE(1'b1)) u_hs (
    .clk(clk), .reset(reset), .en(en0), .port_sel(sel0), .mode(mode0), .data_bus(d0),
    .stall(stall0), .data_out(dout0), .out_valid(v0), .out_ack(ack0), .sel_err(serr0));

  out_port_bank #(.DATA_W(4), .NUM_PORTS(3), .SEL_W(2), .RESET_VAL(4'h9), .HANDSHAKE(1'b0)) u_st (
    .clk(clk), .reset(reset), .en(en1), .port_sel(sel1), .mode(mode1), .data_bus(d1),
    .stall(stall1), .data_out(dout1), .out_valid(v1), .out_ack(ack1), .sel_err(serr1));

  typedef struct {
    logic [1:0]  stall;
    logic [15:0] dout0;
    logic [11:0] dout1;
    logic [3:0]  v0;
    logic [2:0]  v1;
    logic [1:0]  serr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: plain arrays of port values and pending flags.
  logic [3:0] r0[4];
  bit         p0[4];
  logic [3:0] r1[3];
  bit         p1[3];
  bit         se1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [3:0] rmw(input logic [1:0] m, input logic [3:0] q, input logic [3:0] d);
    case (m)
      2'd0:    return d;
      2'd1:    return q | d;
      2'd2:    return q & ~d;
      default: return q ^ d;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin r0[k] = 4'h0; p0[k] = 0; end
    for (int k = 0; k < 3; k++) begin r1[k] = 4'h9; p1[k] = 0; end
    se1 = 0;
  endtask

  // Called just after a rising edge: drive one cycle of inputs, queue the expected outputs.
  task automatic step(input logic e_0, input logic [1:0] s_0, input logic [1:0] m_0,
                      input logic [3:0] dd0, input logic [3:0] a_0,
                      input logic e_1, input logic [1:0] s_1, input logic [1:0] m_1,
                      input logic [3:0] dd1, input logic [2:0] a_1,
                      input bit push, output bit st);
    exp_t ex;
    bit   acc0, acc1, inr1;
    en0 = e_0; sel0 = s_0; mode0 = m_0; d0 = dd0; ack0 = a_0;
    en1 = e_1; sel1 = s_1; mode1 = m_1; d1 = dd1; ack1 = a_1;
    st   = e_0 && p0[s_0] && !a_0[s_0];
    acc0 = e_0 && !st;
    inr1 = (s_1 < 2'd3);
    acc1 = e_1 && inr1;
    for (int k = 0; k < 4; k++) begin ex.dout0[k*4 +: 4] = r0[k]; ex.v0[k] = p0[k]; end
    for (int k = 0; k < 3; k++) begin ex.dout1[k*4 +: 4] = r1[k]; ex.v1[k] = p1[k]; end
    ex.stall = {1'b0, st};
    ex.serr  = {se1, 1'b0};
    if (push) exp_q.push_back(ex);
    for (int k = 0; k < 4; k++) begin
      if (acc0 && s_0 == k) begin r0[k] = rmw(m_0, r0[k], dd0); p0[k] = 1; end
      else if (a_0[k]) p0[k] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      p1[k] = acc1 && (s_1 == k);
      if (p1[k]) r1[k] = rmw(m_1, r1[k], dd1);
    end
    if (e_1 && !inr1) se1 = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_hs", 32'(stall0), 32'(e.stall[0]));
        check("stall_st", 32'(stall1), 32'(e.stall[1]));
        check("data_hs", 32'(dout0), 32'(e.dout0));
        check("data_st", 32'(dout1), 32'(e.dout1));
        check("valid_hs", 32'(v0), 32'(e.v0));
        check("valid_st", 32'(v1), 32'(e.v1));
        check("selerr_hs", 32'(serr0), 32'(e.serr[0]));
        check("selerr_st", 32'(serr1), 32'(e.serr[1]));
      end
    end
  end

  initial begin : driver
    bit         st, hold;
    logic       he;
    logic [1:0] hs, hm;
    logic [3:0] hd;
    reset = 1'b0;
    en0 = 0; sel0 = 0; mode0 = 0; d0 = 0; ack0 = 0;
    en1 = 0; sel1 = 0; mode1 = 0; d1 = 0; ack1 = 0;
    model_reset();
    #12;
    check("rst_data_hs", 32'(dout0), 32'h0);
    check("rst_valid_hs", 32'(v0), 32'h0);
    check("rst_data_st", 32'(dout1), 32'h999);
    check("rst_selerr_st", 32'(serr1), 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Directed: LOAD, mode chain with acks, strobes, out-of-range, stall then ack-release.
    @(posedge clk); #1 step(1, 2'd2, 2'd0, 4'hA, 4'h0, 0, 2'd0, 2'd0, 4'h0, 3'h0, 1, st);
    @(posedge clk); #1 step(1, 2'd1, 2'd0, 4'h5, 4'h0, 1, 2'd2, 2'd0, 4'h3, 3'h0, 1, st);
    @(posedge clk); #1 step(1, 2'd1, 2'd1, 4'hA, 4'h2, 1, 2'd2, 2'd1, 4'h4, 3'h0, 1, st);
    @(posedge clk); #1 step(1, 2'd1, 2'd2, 4'h3, 4'h2, 1, 2'd2, 2'd3, 4'hF, 3'h7, 1, st);
    @(posedge clk); #1 step(1, 2'd1, 2'd3, 4'hF, 4'h2, 1, 2'd3, 2'd0, 4'h5, 3'h0, 1, st);
    @(posedge clk); #1 step(0, 2'd1, 2'd0, 4'h0, 4'h6, 0, 2'd3, 2'd0, 4'h0, 3'h0, 1, st);
    @(posedge clk); #1 step(1, 2'd0, 2'd0, 4'h1, 4'h0, 0, 2'd0, 2'd0, 4'h0, 3'h0, 1, st);
    @(posedge clk); #1 step(1, 2'd0, 2'd0, 4'h7, 4'h0, 0, 2'd0, 2'd0, 4'h0, 3'h0, 1, st);
    @(posedge clk); #1 step(1, 2'd0, 2'd0, 4'h7, 4'h1, 0, 2'd0, 2'd0, 4'h0, 3'h0, 1, st);
    @(posedge clk); #1 step(0, 2'd0, 2'd0, 4'h0, 4'h0, 0, 2'd0, 2'd0, 4'h0, 3'h0, 1, st);

    // Random traffic; a stalled request is held unchanged until accepted.
    hold = 0; he = 0; hs = 0; hm = 0; hd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        he = ($urandom_range(0, 3) != 0);
        hs = 2'($urandom_range(0, 3));
        hm = 2'($urandom_range(0, 3));
        hd = 4'($urandom);
      end
      @(posedge clk); #1;
      step(he, hs, hm, hd, 4'($urandom & $urandom),
           ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           4'($urandom), 3'($urandom), 1, st);
      hold = st;
    end

    // Asynchronous reset dropped in the middle of a stalled cycle.
    @(posedge clk); #1 step(1, 2'd0, 2'd0, 4'h5, 4'hF, 1, 2'd3, 2'd0, 4'h0, 3'h0, 1, st);
    @(posedge clk); #1 step(1, 2'd0, 2'd0, 4'h6, 4'h0, 0, 2'd0, 2'd0, 4'h0, 3'h0, 0, st);
    #1 check("midstall_stall", 32'(stall0), 32'h1);
    #1 reset = 1'b0;
    #1;
    check("async_data_hs", 32'(dout0), 32'h0);
    check("async_valid_hs", 32'(v0), 32'h0);
    check("async_stall_hs", 32'(stall0), 32'h0);
    check("async_data_st", 32'(dout1), 32'h999);
    check("async_selerr_st", 32'(serr1), 32'h0);
    model_reset();
    @(posedge clk); #1 reset = 1'b1;
    en0 = 0; en1 = 0;
    @(posedge clk); #1 step(0, 2'd0, 2'd0, 4'h0, 4'h0, 0, 2'd0, 2'd0, 4'h0, 3'h0, 1, st);
    @(posedge clk); #1 step(1, 2'd0, 2'd0, 4'h6, 4'h0, 1, 2'd1, 2'd0, 4'h2, 3'h0, 1, st);
    @(posedge clk); #1 step(0, 2'd0, 2'd0, 4'h0, 4'h0, 0, 2'd0, 2'd0, 4'h0, 3'h0, 1, st);
    @(posedge clk); #1 step(0, 2'd0, 2'd0, 4'h0, 4'h0, 0, 2'd0, 2'd0, 4'h0, 3'h0, 1, st);

    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
